// File: rtl/pool_accumulator.sv
// pool_accumulator
//   Upstream stage of the 2x2 average-pooling divider. Accepts one feature-map
//   sample per valid/ready handshake, sums WINDOW samples and presents the raw
//   sum. The downstream divider scales it by 0.25.
//
//   Parameters
//     ARITH_TYPE  1 = fixed point (wrapping two's complement), 0 = IEEE float
//     DATA_WIDTH  sample / sum width (16 for Q6.10, 32 for single float)
//     E, M        float exponent / mantissa widths (float mode only)
//     WINDOW      samples per pooled output, 2..16
//
//   Configuration macro
//     POOL_ACC_SAT_EN  fixed mode only: each add saturates to max/min signed
//                      instead of wrapping. Float mode ignores it.
//
//   Ports
//     clk        rising-edge clock
//     reset_n    async active-low reset
//     clear      sync abort of the current window (beats accept)
//     in_data    sample
//     in_valid   sample present
//     in_ready   stage can accept a sample (low in HOLD and during reset)
//     out_data   sum of WINDOW samples
//     out_valid  out_data holds a complete sum
//     out_ready  consumer takes out_data
//
//   state | meaning
//   IDLE  | no partial sum, next accept seeds acc directly
//   ACCUM | partial sum in acc, cnt samples taken so far
//   HOLD  | complete sum on out_data, waiting for out_ready

module pool_accumulator #(
  parameter int ARITH_TYPE = 1,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int WINDOW     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] acc, acc_nxt;
  logic [DATA_WIDTH-1:0] out_data_nxt;
  logic                  out_valid_nxt;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  accept;

  generate
    if (ARITH_TYPE == 1) begin : g_fixed
      logic [DATA_WIDTH-1:0] raw_sum;
      assign raw_sum = acc + in_data;
`ifdef POOL_ACC_SAT_EN
      // Overflow only when both operands share a sign the result lost.
      logic ovf;
      assign ovf = (acc[DATA_WIDTH-1] == in_data[DATA_WIDTH-1]) &&
                   (raw_sum[DATA_WIDTH-1] != acc[DATA_WIDTH-1]);
      assign add_sum = !ovf ? raw_sum :
                       acc[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
      assign add_sum = raw_sum;
`endif
    end else begin : g_float
      floating_point_add #(.E(E), .M(M)) u_fadd (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum)
      );
    end
  endgenerate

  assign in_ready = reset_n & (state != HOLD);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    if (clear) begin
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      acc_nxt       = '0;
      out_data_nxt  = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (accept) begin
            // Seed without the adder so a float -0.0 or NaN sample is kept as-is.
            acc_nxt   = in_data;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_nxt = add_sum;
            if (cnt == CNT_W'(WINDOW - 1)) begin
              out_data_nxt  = add_sum;
              out_valid_nxt = 1'b1;
              cnt_nxt       = '0;
              state_nxt     = HOLD;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end
        end
        default: begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// floating_point_add
//   Combinational IEEE-style adder, sum = a + b, round to nearest even.
//   Subnormal inputs and results flush to zero; overflow gives infinity;
//   inf + -inf gives a quiet NaN.
//
//   Ports
//     a, b  operands, {sign, exponent[E], fraction[M]}
//     sum   result in the same format
module floating_point_add #(
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic [E+M:0] a,
  input  logic [E+M:0] b,
  output logic [E+M:0] sum
);

  // hidden bit + fraction + guard/round/sticky
  localparam int MW = M + 4;

  logic [E+M:0] x, y;
  logic [E-1:0] ex, ey, diff;
  logic [MW-1:0] mx, my, lost, my_al;
  logic [MW:0]   s;
  logic [M+1:0]  mant_r;
  logic          rnd;
  int            e_i;

  always_comb begin
    // x is the operand of larger magnitude; the result takes its sign.
    x     = (a[E+M-1:0] >= b[E+M-1:0]) ? a : b;
    y     = (a[E+M-1:0] >= b[E+M-1:0]) ? b : a;
    ex    = x[E+M-1:M];
    ey    = y[E+M-1:M];
    mx    = (ex == '0) ? '0 : {1'b1, x[M-1:0], 3'b000};
    my    = (ey == '0) ? '0 : {1'b1, y[M-1:0], 3'b000};
    diff  = ex - ey;
    lost  = my & ~({MW{1'b1}} << diff);
    my_al = (my >> diff) | {{(MW-1){1'b0}}, |lost};
    e_i   = int'(ex);

    if (x[E+M] == y[E+M]) s = {1'b0, mx} + {1'b0, my_al};
    else                  s = {1'b0, mx} - {1'b0, my_al};

    if (s[MW]) begin
      s   = (s >> 1) | {{MW{1'b0}}, s[0]};
      e_i = e_i + 1;
    end else begin
      for (int i = 0; i < MW; i++) begin
        if (!s[MW-1] && s != '0) begin
          s   = s << 1;
          e_i = e_i - 1;
        end
      end
    end

    rnd    = s[2] & (s[1] | s[0] | s[3]);
    mant_r = {1'b0, s[MW-1:3]} + (M+2)'(rnd);
    if (mant_r[M+1]) begin
      mant_r = mant_r >> 1;
      e_i    = e_i + 1;
    end

    if (ex == {E{1'b1}}) begin
      sum = (ey == {E{1'b1}} && x[E+M] != y[E+M])
            ? {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}} : x;
    end else if (s == '0 || e_i <= 0) begin
      sum = '0;
    end else if (e_i >= (1 << E) - 1) begin
      sum = {x[E+M], {E{1'b1}}, {M{1'b0}}};
    end else begin
      sum = {x[E+M], E'(e_i), mant_r[M-1:0]};
    end
  end

endmodule

// File: tb/tb_pool_accumulator.sv
// Directed bench for pool_accumulator: a 16-bit fixed-point instance and a
// 32-bit float instance sharing clock, reset and clear.
module tb_pool_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clear;
  logic [15:0] fx_in_data, fx_out_data;
  logic        fx_in_valid, fx_in_ready, fx_out_valid, fx_out_ready;
  logic [31:0] fp_in_data, fp_out_data;
  logic        fp_in_valid, fp_in_ready, fp_out_valid, fp_out_ready;

  int n_checks = 0;
  int n_errors = 0;

  pool_accumulator #(.ARITH_TYPE(1), .DATA_WIDTH(16), .WINDOW(4)) dut_fx (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_data   (fx_in_data),
    .in_valid  (fx_in_valid),
    .in_ready  (fx_in_ready),
    .out_data  (fx_out_data),
    .out_valid (fx_out_valid),
    .out_ready (fx_out_ready)
  );

  pool_accumulator #(.ARITH_TYPE(0), .DATA_WIDTH(32), .E(8), .M(23), .WINDOW(4)) dut_fp (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_data   (fp_in_data),
    .in_valid  (fp_in_valid),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_valid (fp_out_valid),
    .out_ready (fp_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fx_send(input logic [15:0] d);
    @(negedge clk);
    fx_in_valid = 1'b1;
    fx_in_data  = d;
    @(posedge clk);
  endtask

  task automatic fx_stop();
    @(negedge clk);
    fx_in_valid = 1'b0;
  endtask

  task automatic fx_window(input logic [15:0] d0, d1, d2, d3);
    fx_send(d0); fx_send(d1); fx_send(d2); fx_send(d3);
    fx_stop();
  endtask

  task automatic fx_take();
    @(negedge clk);
    fx_in_valid  = 1'b0;
    fx_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fx_out_ready = 1'b0;
  endtask

  task automatic fp_send(input logic [31:0] d);
    @(negedge clk);
    fp_in_valid = 1'b1;
    fp_in_data  = d;
    @(posedge clk);
  endtask

  task automatic fp_window(input logic [31:0] d0, d1, d2, d3);
    fp_send(d0); fp_send(d1); fp_send(d2); fp_send(d3);
    @(negedge clk);
    fp_in_valid = 1'b0;
  endtask

  task automatic fp_take();
    @(negedge clk);
    fp_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fp_out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] sat_exp;
`ifdef POOL_ACC_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hC000;
`endif
    reset_n = 1'b0; clear = 1'b0;
    fx_in_data = '0; fx_in_valid = 1'b0; fx_out_ready = 1'b0;
    fp_in_data = '0; fp_in_valid = 1'b0; fp_out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(fx_out_valid), 32'h0);
    check("rst_out_data",  32'(fx_out_data),  32'h0);
    check("rst_in_ready",  32'(fx_in_ready),  32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(fx_in_ready), 32'h1);

    // basic window, latency
    fx_send(16'h0400); fx_send(16'h0800); fx_send(16'h0C00);
    @(negedge clk);
    fx_in_valid = 1'b1; fx_in_data = 16'h1000;
    check("t1_valid_early", 32'(fx_out_valid), 32'h0);
    @(posedge clk);
    fx_stop();
    check("t1_valid", 32'(fx_out_valid), 32'h1);
    check("t1_data",  32'(fx_out_data),  32'h2800);
    check("t1_in_ready_hold", 32'(fx_in_ready), 32'h0);
    fx_take();
    check("t1_valid_after_take", 32'(fx_out_valid), 32'h0);
    check("t1_in_ready_after_take", 32'(fx_in_ready), 32'h1);

    // overflow: wrap or saturate
    fx_window(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    check("t2_valid", 32'(fx_out_valid), 32'h1);
    check("t2_data",  32'(fx_out_data),  32'(sat_exp));
    fx_take();

    // negative operands cancel
    fx_window(16'hFC00, 16'h0400, 16'hFC00, 16'h0400);
    check("neg_data", 32'(fx_out_data), 32'h0);
    fx_take();

    // stall mid-window, then backpressure with in_valid held high
    fx_send(16'h0100); fx_send(16'h0100);
    fx_stop();
    repeat (3) @(negedge clk);
    check("stall_valid", 32'(fx_out_valid), 32'h0);
    fx_send(16'h0100); fx_send(16'h0100);
    fx_stop();
    check("stall_data", 32'(fx_out_data), 32'h0400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fx_in_valid = 1'b1;
      fx_in_data  = 16'h7777;
      check("bp_data",     32'(fx_out_data),  32'h0400);
      check("bp_valid",    32'(fx_out_valid), 32'h1);
      check("bp_in_ready", 32'(fx_in_ready),  32'h0);
    end
    fx_take();
    fx_window(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    check("bp_next_data", 32'(fx_out_data), 32'h1000);
    fx_take();

    // clear concurrent with a valid sample
    fx_send(16'h0400); fx_send(16'h0400);
    @(negedge clk);
    clear = 1'b1; fx_in_valid = 1'b1; fx_in_data = 16'h0400;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; fx_in_valid = 1'b0;
    check("clr_valid",    32'(fx_out_valid), 32'h0);
    check("clr_in_ready", 32'(fx_in_ready),  32'h1);
    fx_send(16'h0400); fx_send(16'h0400); fx_send(16'h0400);
    fx_stop();
    check("clr_valid_3", 32'(fx_out_valid), 32'h0);
    fx_send(16'h0400);
    fx_stop();
    check("clr_next_valid", 32'(fx_out_valid), 32'h1);
    check("clr_next_data",  32'(fx_out_data),  32'h1000);
    fx_take();

    // clear while holding a result
    fx_window(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check("clr_hold_valid",    32'(fx_out_valid), 32'h0);
    check("clr_hold_in_ready", 32'(fx_in_ready),  32'h1);
    fx_window(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    check("clr_hold_next", 32'(fx_out_data), 32'h1000);
    fx_take();

    // async reset mid-window
    fx_send(16'h0400); fx_send(16'h0400); fx_send(16'h0400);
    @(negedge clk);
    fx_in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid",    32'(fx_out_valid), 32'h0);
    check("mid_rst_data",     32'(fx_out_data),  32'h0);
    check("mid_rst_in_ready", 32'(fx_in_ready),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    fx_window(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    check("mid_rst_next_valid", 32'(fx_out_valid), 32'h1);
    check("mid_rst_next_data",  32'(fx_out_data),  32'h1000);
    fx_take();

    // float mode
    fp_window(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    check("fp_valid", 32'(fp_out_valid), 32'h1);
    check("fp_ones",  fp_out_data, 32'h40800000);
    fp_take();
    fp_window(32'h3FC00000, 32'h40100000, 32'hBF800000, 32'h3F000000);
    check("fp_mixed", fp_out_data, 32'h40500000);
    fp_take();
    check("fp_valid_after_take", 32'(fp_out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
